// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - LEGv8 instruction-fetch stage: PC, IF/ID register, exception entry/return.
module fetch_unit #(
  parameter int           N          = 64,
  parameter logic [N-1:0] EXC_VECTOR = 64'h0000_0000_0000_00D8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall_i,
  input  logic         pcsrc_i,
  input  logic [N-1:0] pcbranch_i,
  input  logic         exc_i,
  input  logic [N-1:0] exc_pc_i,
  input  logic         eret_i,
  output logic [5:0]   imem_addr_o,
  input  logic [31:0]  instr_i,
  output logic [N-1:0] if_pc_o,
  output logic [31:0]  if_instr_o,
  output logic         if_valid_o,
  output logic [N-1:0] elr_o,
  output logic         in_handler_o
);

  typedef enum logic {NORMAL, HANDLER} mode_t;

  mode_t        state;
  logic [N-1:0] pc;
  logic [N-1:0] elr;
  logic         exc_take;
  logic         eret_take;
  logic         redirect;

  // exc only counts in NORMAL and eret only in HANDLER, so the two are mutually exclusive
  assign exc_take  = exc_i && (state == NORMAL);
  assign eret_take = eret_i && (state == HANDLER);
  assign redirect  = exc_take || eret_take || pcsrc_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= NORMAL;
      pc    <= '0;
      elr   <= '0;
    end else if (exc_take) begin
      state <= HANDLER;
      pc    <= EXC_VECTOR;
      elr   <= exc_pc_i;
    end else if (eret_take) begin
      state <= NORMAL;
      pc    <= elr;
    end else if (pcsrc_i) begin
      pc <= {pcbranch_i[N-1:2], 2'b00};
    end else if (!stall_i) begin
      pc <= pc + N'(4);
    end
  end

  // Redirect flushes the wrong-path slot even when the hazard unit is stalling
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_pc_o    <= '0;
      if_instr_o <= '0;
      if_valid_o <= 1'b0;
    end else if (redirect) begin
      if_pc_o    <= '0;
      if_instr_o <= '0;
      if_valid_o <= 1'b0;
    end else if (!stall_i) begin
      if_pc_o    <= pc;
      if_instr_o <= instr_i;
      if_valid_o <= 1'b1;
    end
  end

  assign imem_addr_o  = pc[7:2];
  assign elr_o        = elr;
  assign in_handler_o = (state == HANDLER);

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed bench for fetch_unit with a combinational ROM model.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stall_i;
  logic        pcsrc_i;
  logic [63:0] pcbranch_i;
  logic        exc_i;
  logic [63:0] exc_pc_i;
  logic        eret_i;
  logic [5:0]  imem_addr_o;
  logic [31:0] instr_i;
  logic [63:0] if_pc_o;
  logic [31:0] if_instr_o;
  logic        if_valid_o;
  logic [63:0] elr_o;
  logic        in_handler_o;

  int n_cmp;
  int n_err;

  fetch_unit dut (
    .clk          (clk),
    .reset        (reset),
    .stall_i      (stall_i),
    .pcsrc_i      (pcsrc_i),
    .pcbranch_i   (pcbranch_i),
    .exc_i        (exc_i),
    .exc_pc_i     (exc_pc_i),
    .eret_i       (eret_i),
    .imem_addr_o  (imem_addr_o),
    .instr_i      (instr_i),
    .if_pc_o      (if_pc_o),
    .if_instr_o   (if_instr_o),
    .if_valid_o   (if_valid_o),
    .elr_o        (elr_o),
    .in_handler_o (in_handler_o)
  );

  function automatic logic [31:0] rom(input logic [5:0] a);
    return 32'h8B00_0000 | (32'(a) * 32'h0001_0101);
  endfunction

  assign instr_i = rom(imem_addr_o);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check_if(input string tag, input logic [63:0] pc, input logic v, input logic [31:0] ins);
    check_eq({tag, ".if_pc"}, if_pc_o, pc);
    check_eq({tag, ".if_valid"}, 64'(if_valid_o), 64'(v));
    check_eq({tag, ".if_instr"}, 64'(if_instr_o), 64'(ins));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    stall_i = 1'b0;
    pcsrc_i = 1'b0;
    pcbranch_i = '0;
    exc_i = 1'b0;
    exc_pc_i = '0;
    eret_i = 1'b0;

    #1;
    check_eq("rst.imem", 64'(imem_addr_o), 64'd0);
    check_if("rst", 64'h0, 1'b0, 32'h0);
    check_eq("rst.elr", elr_o, 64'h0);
    check_eq("rst.hnd", 64'(in_handler_o), 64'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_eq("rst.imem_held", 64'(imem_addr_o), 64'd0);

    // free-running fetch
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq($sformatf("run%0d.imem", i), 64'(imem_addr_o), 64'(i + 1));
      check_if($sformatf("run%0d", i), 64'(i * 4), 1'b1, rom(6'(i)));
    end

    // two-cycle stall at pc 0x10
    stall_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check_eq($sformatf("stall%0d.imem", i), 64'(imem_addr_o), 64'd4);
      check_if($sformatf("stall%0d", i), 64'hC, 1'b1, rom(6'd3));
    end
    stall_i = 1'b0;
    step();
    check_eq("resume.imem", 64'(imem_addr_o), 64'd5);
    check_if("resume", 64'h10, 1'b1, rom(6'd4));
    step();
    step();
    step();
    check_eq("pre_br.imem", 64'(imem_addr_o), 64'd8);

    // branch to 0x83 -> 0x80
    pcsrc_i = 1'b1;
    pcbranch_i = 64'h83;
    step();
    pcsrc_i = 1'b0;
    check_eq("br.imem", 64'(imem_addr_o), 64'd32);
    check_if("br.bubble", 64'h0, 1'b0, 32'h0);
    step();
    check_if("br.target", 64'h80, 1'b1, rom(6'd32));

    // exception with stall also high
    exc_i = 1'b1;
    exc_pc_i = 64'h44;
    stall_i = 1'b1;
    step();
    exc_i = 1'b0;
    stall_i = 1'b0;
    check_eq("exc.imem", 64'(imem_addr_o), 64'd54);
    check_eq("exc.elr", elr_o, 64'h44);
    check_eq("exc.hnd", 64'(in_handler_o), 64'd1);
    check_if("exc.flush", 64'h0, 1'b0, 32'h0);
    step();
    check_if("hnd.first", 64'hD8, 1'b1, rom(6'd54));

    // nested exception ignored
    exc_i = 1'b1;
    exc_pc_i = 64'h99C;
    step();
    exc_i = 1'b0;
    check_eq("nest.elr", elr_o, 64'h44);
    check_eq("nest.hnd", 64'(in_handler_o), 64'd1);
    check_eq("nest.imem", 64'(imem_addr_o), 64'd56);
    check_if("nest", 64'hDC, 1'b1, rom(6'd55));

    // exception return
    eret_i = 1'b1;
    step();
    check_eq("eret.imem", 64'(imem_addr_o), 64'd17);
    check_eq("eret.hnd", 64'(in_handler_o), 64'd0);
    check_if("eret.flush", 64'h0, 1'b0, 32'h0);

    // eret in NORMAL ignored (eret_i still high)
    step();
    eret_i = 1'b0;
    check_eq("eret_norm.imem", 64'(imem_addr_o), 64'd18);
    check_eq("eret_norm.hnd", 64'(in_handler_o), 64'd0);
    check_if("eret_norm", 64'h44, 1'b1, rom(6'd17));

    // exc and eret together: NORMAL takes exc, HANDLER takes eret
    exc_i = 1'b1;
    eret_i = 1'b1;
    exc_pc_i = 64'h50;
    step();
    check_eq("both_n.imem", 64'(imem_addr_o), 64'd54);
    check_eq("both_n.hnd", 64'(in_handler_o), 64'd1);
    check_eq("both_n.elr", elr_o, 64'h50);
    exc_pc_i = 64'h70;
    step();
    exc_i = 1'b0;
    eret_i = 1'b0;
    check_eq("both_h.imem", 64'(imem_addr_o), 64'd20);
    check_eq("both_h.hnd", 64'(in_handler_o), 64'd0);
    check_eq("both_h.elr", elr_o, 64'h50);

    // async reset pulse between edges while in HANDLER
    exc_i = 1'b1;
    exc_pc_i = 64'h60;
    step();
    exc_i = 1'b0;
    check_eq("pre_rst.hnd", 64'(in_handler_o), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("arst.imem", 64'(imem_addr_o), 64'd0);
    check_eq("arst.hnd", 64'(in_handler_o), 64'd0);
    check_eq("arst.elr", elr_o, 64'h0);
    check_if("arst", 64'h0, 1'b0, 32'h0);
    reset = 1'b0;
    step();
    check_eq("post_rst.imem", 64'(imem_addr_o), 64'd1);
    check_if("post_rst", 64'h0, 1'b1, rom(6'd0));

    // wrap of the ROM address past 0xFC
    pcsrc_i = 1'b1;
    pcbranch_i = 64'hFC;
    step();
    pcsrc_i = 1'b0;
    check_eq("wrap.imem63", 64'(imem_addr_o), 64'd63);
    step();
    check_eq("wrap.imem0", 64'(imem_addr_o), 64'd0);
    check_if("wrap.fc", 64'hFC, 1'b1, rom(6'd63));
    step();
    check_eq("wrap.imem1", 64'(imem_addr_o), 64'd1);
    check_if("wrap.100", 64'h100, 1'b1, rom(6'd0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
